univ_shift_reg_burst: RTL
=========================

Name: univ_shift_reg_burst

Overview:
Parametrised universal shift register, WIDTH bits wide, with eight operating modes. Modes cover hold, logical shift, rotate, arithmetic shift, parallel load and clear. A burst engine performs a programmed number of shift/rotate steps autonomously, reporting busy and done. It is the next-generation replacement for the fixed 4-bit mux+DFF universal shift register in datapath and serialiser logic.

Parameters:
WIDTH, 8, register width in bits; must be >= 2.
CNT_W, 4, width of the burst count input; maximum burst length is 2^CNT_W-1.

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-low reset.
en  input  1  direct-operation enable; used only while idle.
mode  input  3  operation select (encoding below).
sin_l  input  1  serial input entering the MSB on shift right.
sin_r  input  1  serial input entering the LSB on shift left.
d  input  WIDTH  parallel load data.
start  input  1  burst request; sampled only while idle.
cnt  input  CNT_W  burst step count, sampled with start.
q  output  WIDTH  register contents.
so_msb  output  1  q[WIDTH-1], combinational from q.
so_lsb  output  1  q[0], combinational from q.
busy  output  1  burst in progress.
done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset: rst low clears state immediately, independent of clk: q=0, busy=0, done=0, internal counter=0, latched mode=000.
- Reset mid-burst abandons the burst. No resumption occurs after rst returns high; the block is idle.
- Mode encoding, applied to q:
  - 000 hold.
  - 001 SHR: {sin_l, q[W-1:1]}.
  - 010 SHL: {q[W-2:0], sin_r}.
  - 011 LOAD: d.
  - 100 ROTR: {q[0], q[W-1:1]}.
  - 101 ROTL: {q[W-2:0], q[W-1]}.
  - 110 ASHR: {q[W-1], q[W-1:1]}.
  - 111 CLEAR: 0.
- States: IDLE and BURST.
- IDLE, start=0, en=1: apply mode at the edge; q updates one cycle after the inputs are sampled.
- IDLE, en=0, start=0: q holds.
- IDLE, start=1: start has priority over en.
  - Shift-type modes are 001, 010, 100, 101 and 110.
  - If mode is shift-type and cnt>=1: at the sampling edge, latch mode and cnt, set busy=1 and go to BURST. q is not modified at that edge.
  - If mode is shift-type and cnt=0: no state change except done=1 for the following cycle; busy stays 0.
  - If mode is not shift-type (000, 011, 111): treat as a direct operation (same as en=1); no busy, no done.
- BURST: on each rising edge, apply the latched mode once and decrement the counter.
  - sin_l and sin_r are sampled live at each step edge.
  - en, mode, d, start and cnt are ignored.
  - At the edge performing the final step: busy->0, done->1 for exactly one cycle, return to IDLE.
  - Result is visible N+1 cycles after start is sampled; busy is high for exactly N cycles.
- done is high only in the cycle after burst completion (or after a cnt=0 start). It is never asserted together with busy.
- In the completion cycle (done=1, IDLE), a new start or en is accepted normally (back-to-back bursts allowed).
- Maximum burst (cnt all ones) has no special handling; the counter never wraps.
- No combinational path from inputs to q/busy/done; so_msb and so_lsb derive from q only.

Test Plan:
All scenarios use WIDTH=8, CNT_W=4.
1. Reset: load 0xA5, then drive rst low between clock edges -> q=0x00, busy=0, done=0 before the next edge. q stays 0 while rst is low.
2. Load/hold: en=1, mode=011, d=0xB4 -> q=0xB4 after one edge. Then en=0, mode=011, d=0xFF for 3 edges -> q stays 0xB4.
3. Direct ops, each starting from q=0x81:
   - SHR, sin_l=0 -> 0x40.
   - SHL, sin_r=1 -> 0x03.
   - ROTR -> 0xC0.
   - ROTL -> 0x03.
   - ASHR -> 0xC0.
   - CLEAR -> 0x00.
   - so_msb and so_lsb track q each time.
4. Burst: q=0x96; start=1, mode=101, cnt=3 -> busy=1 for 3 cycles and q=0xB4 afterwards, with done=1 for one cycle as busy falls. Toggling mode, d and start during busy has no effect.
5. Edge starts:
   - start with cnt=0, mode=001 -> done pulses once, busy never rises, q unchanged.
   - start with mode=011, cnt=5 -> acts as a load, no busy/done.
   - start and en both high, mode=001, cnt=2 -> burst taken.
6. Reset mid-burst: q=0xFF, start SHR, sin_l=0, cnt=6; assert rst after the 2nd step -> q=0, busy=0, done=0. After release the block stays idle with q=0 and no done pulse.

Source files
------------

// File: rtl/univ_shift_reg_burst.sv
`default_nettype none
// ============================================================================
// Module   : univ_shift_reg_burst
// Brief    : WIDTH-bit universal shift register with eight modes and an
//            autonomous multi-step shift/rotate burst engine.
// Revision : 1.0
// ============================================================================
module univ_shift_reg_burst #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic [CNT_W-1:0] cnt,
    output logic [WIDTH-1:0] q,
    output logic             so_msb,
    output logic             so_lsb,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] c_MODE_HOLD  = 3'b000;
    localparam logic [2:0] c_MODE_SHR   = 3'b001;
    localparam logic [2:0] c_MODE_SHL   = 3'b010;
    localparam logic [2:0] c_MODE_LOAD  = 3'b011;
    localparam logic [2:0] c_MODE_ROTR  = 3'b100;
    localparam logic [2:0] c_MODE_ROTL  = 3'b101;
    localparam logic [2:0] c_MODE_ASHR  = 3'b110;
    localparam logic [2:0] c_MODE_CLEAR = 3'b111;

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [2:0]         mode_q,  mode_d;
    logic               done_q,  done_d;

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] ld,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] res;
        res = cur;
        case (op)
            c_MODE_HOLD:  res = cur;
            c_MODE_SHR:   res = {sl, cur[WIDTH-1:1]};
            c_MODE_SHL:   res = {cur[WIDTH-2:0], sr};
            c_MODE_LOAD:  res = ld;
            c_MODE_ROTR:  res = {cur[0], cur[WIDTH-1:1]};
            c_MODE_ROTL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            c_MODE_ASHR:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
            c_MODE_CLEAR: res = '0;
            default:      res = cur;
        endcase
        return res;
    endfunction

    function automatic logic is_shift(input logic [2:0] op);
        return (op == c_MODE_SHR)  || (op == c_MODE_SHL) ||
               (op == c_MODE_ROTR) || (op == c_MODE_ROTL) ||
               (op == c_MODE_ASHR);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            mode_q  <= c_MODE_HOLD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && is_shift(mode)) begin
                    // q is left untouched on the accepting edge; steps begin next edge
                    if (cnt != '0) begin
                        mode_d  = mode;
                        cnt_d   = cnt;
                        state_d = BURST;
                    end else begin
                        done_d  = 1'b1;
                    end
                end else if (start || en) begin
                    shreg_d = apply_op(mode, shreg_q, d, sin_l, sin_r);
                end
            end
            BURST: begin
                shreg_d = apply_op(mode_q, shreg_q, d, sin_l, sin_r);
                cnt_d   = cnt_q - c_CNT_ONE;
                if (cnt_q == c_CNT_ONE) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign q      = shreg_q;
    assign so_msb = shreg_q[WIDTH-1];
    assign so_lsb = shreg_q[0];
    assign busy   = (state_q == BURST);
    assign done   = done_q;

endmodule
`default_nettype wire
